// File: rtl/fp_det_pkg.sv
// Shared definitions for the determinant accelerator's floating-point datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the arithmetic-unit latencies the schedulers are built around, the two
// IEEE-754 constants the engines use, and the tag carried alongside each
// operation through the shared multiplier.
package fp_det_pkg;

    // Enabled-cycle latencies of the floating-point cores.
    localparam int ADDER_LATENCY     = 7;
    localparam int MULTPLIER_LATENCY = 5;
    localparam int DIVIDER_LATENCY   = 6;

    // Single-precision constants.
    localparam logic [31:0] NaN       = 32'h7FC0_0000;
    localparam logic [31:0] FLOAT_ONE = 32'h3F80_0000;

    // Width of a requester id; covers up to 8 requesters.
    localparam int TAG_ID_W = 3;

    // Per-operation tag travelling beside the multiplier pipeline.
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fp_mul_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks one requester per cycle, searching upward from a rotating pointer.
// Latency: grant is combinational from req; pointer updates at the edge ending a grant cycle.
// Backpressure: en_i low forces grant to zero and freezes the pointer.
//
// Ports:
//   clk_i, reset_i  clock and synchronous active-high reset (pointer -> 0)
//   en_i            arbitration enable (low during stall or reset)
//   req_i           per-requester request vector
//   grant_o         one-hot grant, zero when nothing is granted
//   gnt_vld_o       a grant is being issued this cycle
//   gnt_id_o        binary index of the granted requester
module rr_arbiter
    import fp_det_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                en_i,
    input  logic [NUM_REQ-1:0]  req_i,
    output logic [NUM_REQ-1:0]  grant_o,
    output logic                gnt_vld_o,
    output logic [TAG_ID_W-1:0] gnt_id_o
);

    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    logic [TAG_ID_W-1:0] ptr_q;
    logic [TAG_ID_W-1:0] ptr_d;
    // One bit wider than the pointer so ptr+i can be range-checked before wrapping.
    logic [TAG_ID_W:0]   cand;
    logic                hit;

    // Walk the requesters starting at the pointer; the first one asserting
    // req wins. Later hits are ignored once gnt_vld_o is set, which keeps
    // the grant one-hot.
    always_comb begin
        grant_o   = '0;
        gnt_vld_o = 1'b0;
        gnt_id_o  = '0;
        cand      = '0;
        hit       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (TAG_ID_W+1)'(i);
            if (cand >= (TAG_ID_W+1)'(NUM_REQ)) begin
                cand = cand - (TAG_ID_W+1)'(NUM_REQ);
            end
            hit = |(req_i & (ONE << cand));
            if (en_i && hit && !gnt_vld_o) begin
                gnt_vld_o = 1'b1;
                gnt_id_o  = cand[TAG_ID_W-1:0];
                grant_o   = ONE << cand;
            end
        end
    end

    // The requester after the winner gets first look next time.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld_o) begin
            ptr_d = (gnt_id_o == TAG_ID_W'(NUM_REQ-1)) ? '0 : gnt_id_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one pipelined fp_mult between NUM_REQ requesters and routes each product back to its issuer.
// Latency: grant in cycle T -> rsp_valid in cycle T+1+LATENCY, plus one cycle per stall cycle in between.
// Backpressure: stall blocks grants and freezes both the multiplier (mul_clk_en=0) and the tag pipeline.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset (fp_mult aclr shares this reset)
//   stall                 global freeze
//   req, req_dataa/datab  per-requester request and packed operands (requester i at [i*DATA_W +: DATA_W])
//   grant                 one-hot, combinational: operands of that requester are taken this cycle
//   mul_dataa/datab       registered operands to fp_mult
//   mul_clk_en            fp_mult clock enable (= !stall)
//   mul_result, mul_nan   fp_mult outputs
//   rsp_valid             one-hot: result for that requester is on rsp_data/rsp_nan this cycle
//   rsp_data, rsp_nan     fp_mult outputs passed straight through
//   in_flight             issued operations not yet returned
//   idle                  nothing in flight and nothing requesting
module fp_mul_arbiter
    import fp_det_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = MULTPLIER_LATENCY,
    parameter int DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_dataa,
    input  logic [NUM_REQ*DATA_W-1:0]   req_datab,
    output logic [NUM_REQ-1:0]          grant,
    output logic [DATA_W-1:0]           mul_dataa,
    output logic [DATA_W-1:0]           mul_datab,
    output logic                        mul_clk_en,
    input  logic [DATA_W-1:0]           mul_result,
    input  logic                        mul_nan,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_nan,
    output logic [3:0]                  in_flight,
    output logic                        idle
);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                arb_en;
    logic [NUM_REQ-1:0]  arb_grant;
    logic                arb_vld;
    logic [TAG_ID_W-1:0] arb_id;

    assign arb_en = !stall && !reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk_i     (clk),
        .reset_i   (reset),
        .en_i      (arb_en),
        .req_i     (req),
        .grant_o   (arb_grant),
        .gnt_vld_o (arb_vld),
        .gnt_id_o  (arb_id)
    );

    assign grant = arb_grant;

    // ------------------------------------------------------------------
    // Operand issue register
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [DATA_W-1:0] mul_dataa_q;
    logic [DATA_W-1:0] mul_datab_q;

    // Grant is one-hot, so at most one slice is ever selected.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_a = req_dataa[i*DATA_W +: DATA_W];
                sel_b = req_datab[i*DATA_W +: DATA_W];
            end
        end
    end

    // Operands hold when nothing is granted; the multiplier still computes
    // on them, but no tag is valid so the product is never delivered.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_dataa_q <= '0;
            mul_datab_q <= '0;
        end else if (arb_vld) begin
            mul_dataa_q <= sel_a;
            mul_datab_q <= sel_b;
        end
    end

    assign mul_dataa  = mul_dataa_q;
    assign mul_datab  = mul_datab_q;
    assign mul_clk_en = !stall;

    // ------------------------------------------------------------------
    // Tag pipeline
    // ------------------------------------------------------------------
    // Stage 0 is loaded at the same edge that loads the operand register.
    // The operands then need LATENCY enabled edges inside fp_mult, so stage
    // LATENCY lines up with mul_result. Both are gated by the same !stall,
    // which keeps them in lock-step through any stall pattern.
    tag_t tag_q [0:LATENCY];
    tag_t tag0_d;

    always_comb begin
        tag0_d       = '0;
        tag0_d.valid = arb_vld;
        tag0_d.id    = arb_id;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else if (!stall) begin
            tag_q[0] <= tag0_d;
            for (int i = 1; i <= LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    // A result sitting at the last stage during a stall is held, not
    // presented, so it fires exactly once in the first non-stall cycle.
    logic rsp_fire;

    assign rsp_fire = tag_q[LATENCY].valid && !stall && !reset;

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = rsp_fire && (tag_q[LATENCY].id == TAG_ID_W'(i));
        end
    end

    assign rsp_data = mul_result;
    assign rsp_nan  = mul_nan;

    // ------------------------------------------------------------------
    // Occupancy
    // ------------------------------------------------------------------
    // Bounded by LATENCY+1 because each tag stage holds at most one op.
    logic [3:0] in_flight_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_flight_q <= '0;
        end else begin
            unique case ({arb_vld, rsp_fire})
                2'b10:   in_flight_q <= in_flight_q + 4'd1;
                2'b01:   in_flight_q <= in_flight_q - 4'd1;
                default: in_flight_q <= in_flight_q;
            endcase
        end
    end

    assign in_flight = in_flight_q;
    assign idle      = (in_flight_q == 4'd0) && (req == '0);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
module tb_fp_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int LATENCY = 5;
    localparam int DATA_W  = 32;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      stall;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_dataa;
    logic [NUM_REQ*DATA_W-1:0] req_datab;
    logic [NUM_REQ-1:0]        grant;
    logic [DATA_W-1:0]         mul_dataa;
    logic [DATA_W-1:0]         mul_datab;
    logic                      mul_clk_en;
    logic [DATA_W-1:0]         mul_result;
    logic                      mul_nan;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_nan;
    logic [3:0]                in_flight;
    logic                      idle;

    int checks = 0;
    int errors = 0;

    fp_mul_arbiter #(
        .NUM_REQ (NUM_REQ),
        .LATENCY (LATENCY),
        .DATA_W  (DATA_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .req        (req),
        .req_dataa  (req_dataa),
        .req_datab  (req_datab),
        .grant      (grant),
        .mul_dataa  (mul_dataa),
        .mul_datab  (mul_datab),
        .mul_clk_en (mul_clk_en),
        .mul_result (mul_result),
        .mul_nan    (mul_nan),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_nan    (rsp_nan),
        .in_flight  (in_flight),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    // Stand-in for fp_mult: a product lookup for the directed operand pairs,
    // delayed by LATENCY enabled edges and cleared by the shared reset.
    function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: prod = 32'h40000000; // 1*2
            {32'h40000000, 32'h40000000}: prod = 32'h40800000; // 2*2
            {32'h40400000, 32'h40000000}: prod = 32'h40C00000; // 3*2
            {32'h40800000, 32'h40000000}: prod = 32'h41000000; // 4*2
            {32'h3F800000, 32'h40A00000}: prod = 32'h40A00000; // 1*5
            {32'h7FC00000, 32'h3F800000}: prod = 32'h7FC00000; // NaN*1
            default:                      prod = 32'h00000000;
        endcase
    endfunction

    logic [31:0] mp [0:LATENCY-1];
    logic        mn [0:LATENCY-1];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                mp[i] <= '0;
                mn[i] <= 1'b0;
            end
        end else if (mul_clk_en) begin
            mp[0] <= prod(mul_dataa, mul_datab);
            mn[0] <= (prod(mul_dataa, mul_datab) == 32'h7FC00000);
            for (int i = 1; i < LATENCY; i++) begin
                mp[i] <= mp[i-1];
                mn[i] <= mn[i-1];
            end
        end
    end

    assign mul_result = mp[LATENCY-1];
    assign mul_nan    = mn[LATENCY-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_dataa[i*DATA_W +: DATA_W] = a;
        req_datab[i*DATA_W +: DATA_W] = b;
    endtask

    // Structural invariants sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            chk("rsp_onehot0", 32'($onehot0(rsp_valid)), 32'd1);
            chk("in_flight_max", 32'(in_flight <= 4'(LATENCY+1)), 32'd1);
            if (dut.tag_q[LATENCY].valid) begin
                chk("tag_id_range", 32'(dut.tag_q[LATENCY].id < 3'(NUM_REQ)), 32'd1);
            end
        end
    end

    logic [31:0] fair_prod [0:3];
    logic [3:0]  eg;
    logic [3:0]  er;
    int          exp_if;
    int          ng;
    int          nr;

    initial begin
        fair_prod[0] = 32'h40000000;
        fair_prod[1] = 32'h40800000;
        fair_prod[2] = 32'h40C00000;
        fair_prod[3] = 32'h41000000;

        reset = 1'b1; stall = 1'b0; req = '0; req_dataa = '0; req_datab = '0;

        // ---------------- reset state ----------------
        settle();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_in_flight", 32'(in_flight), 32'd0);
        chk("rst_mul_dataa", mul_dataa, 32'd0);
        chk("rst_mul_datab", mul_datab, 32'd0);
        tick();
        req = 4'b0001;
        settle();
        chk("rst_grant_blocked", 32'(grant), 32'd0);
        chk("rst_idle_with_req", 32'(idle), 32'd0);
        tick();

        // ---------------- single issue: 3.0 x 2.0 on requester 1 ----------------
        reset = 1'b0;
        set_op(1, 32'h40400000, 32'h40000000);
        req = 4'b0010;
        settle();
        chk("single_grant", 32'(grant), 32'b0010);
        chk("single_if_c0", 32'(in_flight), 32'd0);
        tick();
        req = '0;
        settle();
        chk("single_if_c1", 32'(in_flight), 32'd1);
        chk("single_mul_dataa", mul_dataa, 32'h40400000);
        chk("single_mul_datab", mul_datab, 32'h40000000);
        chk("single_rsp_c1", 32'(rsp_valid), 32'd0);
        tick();
        for (int c = 2; c <= 5; c++) begin
            settle();
            chk("single_rsp_early", 32'(rsp_valid), 32'd0);
            tick();
        end
        settle();
        chk("single_rsp_c6", 32'(rsp_valid), 32'b0010);
        chk("single_data", rsp_data, 32'h40C00000);
        chk("single_nan", 32'(rsp_nan), 32'd0);
        chk("single_if_c6", 32'(in_flight), 32'd1);
        tick();
        settle();
        chk("single_rsp_c7", 32'(rsp_valid), 32'd0);
        chk("single_if_c7", 32'(in_flight), 32'd0);
        chk("single_idle_c7", 32'(idle), 32'd1);
        tick();

        // ---------------- fairness: all four requesting for 8 cycles ----------------
        reset = 1'b1;
        settle();
        tick();
        reset = 1'b0;
        set_op(0, 32'h3F800000, 32'h40000000);
        set_op(1, 32'h40000000, 32'h40000000);
        set_op(2, 32'h40400000, 32'h40000000);
        set_op(3, 32'h40800000, 32'h40000000);
        for (int k = 0; k < 16; k++) begin
            req = (k < 8) ? 4'b1111 : 4'b0000;
            settle();
            eg = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
            chk("fair_grant", 32'(grant), 32'(eg));
            er = (k >= 6 && k < 14) ? (4'b0001 << ((k - 6) % 4)) : 4'b0000;
            chk("fair_rsp_valid", 32'(rsp_valid), 32'(er));
            if (k >= 6 && k < 14) begin
                chk("fair_rsp_data", rsp_data, fair_prod[(k - 6) % 4]);
            end
            ng = (k < 8) ? k : 8;
            nr = (k < 6) ? 0 : ((k - 6 < 8) ? k - 6 : 8);
            exp_if = ng - nr;
            chk("fair_in_flight", 32'(in_flight), 32'(exp_if));
            tick();
        end

        // ---------------- stall: 1.0 x 5.0, stall cycles 2..4 ----------------
        set_op(0, 32'h3F800000, 32'h40A00000);
        for (int k = 0; k < 12; k++) begin
            req   = (k == 0) ? 4'b0001 : 4'b0000;
            stall = (k >= 2 && k <= 4);
            settle();
            if (k == 0) chk("stall_grant", 32'(grant), 32'b0001);
            chk("stall_clk_en", 32'(mul_clk_en), (k >= 2 && k <= 4) ? 32'd0 : 32'd1);
            chk("stall_rsp_valid", 32'(rsp_valid), (k == 9) ? 32'b0001 : 32'd0);
            if (k == 9) chk("stall_rsp_data", rsp_data, 32'h40A00000);
            tick();
        end
        stall = 1'b0;

        // ---------------- stall blocking a request ----------------
        set_op(2, 32'h40800000, 32'h40000000);
        for (int k = 0; k < 10; k++) begin
            stall = (k < 2);
            req   = (k <= 2) ? 4'b0100 : 4'b0000;
            settle();
            chk("block_grant", 32'(grant), (k == 2) ? 32'b0100 : 32'd0);
            chk("block_rsp_valid", 32'(rsp_valid), (k == 8) ? 32'b0100 : 32'd0);
            if (k == 8) chk("block_rsp_data", rsp_data, 32'h41000000);
            tick();
        end

        // ---------------- NaN propagation on requester 3 ----------------
        set_op(3, 32'h7FC00000, 32'h3F800000);
        for (int k = 0; k < 8; k++) begin
            req = (k == 0) ? 4'b1000 : 4'b0000;
            settle();
            if (k == 0) chk("nan_grant", 32'(grant), 32'b1000);
            chk("nan_rsp_valid", 32'(rsp_valid), (k == 6) ? 32'b1000 : 32'd0);
            if (k == 6) begin
                chk("nan_flag", 32'(rsp_nan), 32'd1);
                chk("nan_data", rsp_data, 32'h7FC00000);
            end
            tick();
        end

        // ---------------- reset with three operations in flight ----------------
        for (int k = 0; k < 13; k++) begin
            case (k)
                0:       req = 4'b0001;
                1:       req = 4'b0010;
                2:       req = 4'b0100;
                3:       req = 4'b0001;
                default: req = 4'b0000;
            endcase
            reset = (k == 3);
            settle();
            if (k < 3) chk("mrst_grant", 32'(grant), 32'(4'b0001 << k));
            if (k == 3) begin
                chk("mrst_if_before", 32'(in_flight), 32'd3);
                chk("mrst_grant_in_reset", 32'(grant), 32'd0);
            end
            if (k == 4) chk("mrst_if_after", 32'(in_flight), 32'd0);
            if (k >= 3) chk("mrst_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end

        // Pointer back at 0: requester 0 wins over 3. Then requester 3 issues.
        set_op(3, 32'h40400000, 32'h40000000);
        for (int k = 0; k < 9; k++) begin
            req = (k == 0) ? 4'b1001 : ((k == 1) ? 4'b1000 : 4'b0000);
            settle();
            if (k == 0) chk("post_rst_ptr", 32'(grant), 32'b0001);
            if (k == 1) chk("post_rst_req3", 32'(grant), 32'b1000);
            chk("post_rst_rsp", 32'(rsp_valid),
                (k == 6) ? 32'b0001 : ((k == 7) ? 32'b1000 : 32'd0));
            if (k == 6) chk("post_rst_data0", rsp_data, 32'h40A00000);
            if (k == 7) chk("post_rst_data3", rsp_data, 32'h40C00000);
            if (k == 8) chk("post_rst_idle", 32'(idle), 32'd1);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
